fe_branch_tracker: RTL

//  Front-end next-PC generator and speculative-branch checkpoint queue. Consumes per-branch take/speculative

---
 rtl/fe_branch_tracker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fe_branch_tracker.sv
// Front-end next-PC generator with an in-order checkpoint queue that holds
// the not-taken alternate PC of every speculative branch still in flight.
//
// Ports:
//   clk_i, reset_n_i            clock, synchronous active-low reset
//   fetch_ready_i               I-cache accepts pc_o this cycle
//   pc_o, pc_valid_o            current fetch PC and its valid flag
//   br_valid_i, br_take_i,      decoded branch with static take and
//   br_spec_i, br_pc_i,         speculative decisions, its own PC
//   br_target_i                 and its target PC
//   resolve_valid_i,            back end resolves the oldest speculative
//   resolve_mispred_i           branch, flagging a misprediction
//   stall_o                     queue full, speculative branch refused
//   redirect_o, redirect_pc_o   one-cycle pulse after a mispredict flush
//   spec_count_o                occupied checkpoint entries
//   err_o                       sticky: resolve seen with an empty queue
module fe_branch_tracker #(
    parameter int unsigned     PC_W        = 16,
    parameter int unsigned     INSTR_BYTES = 2,
    parameter int unsigned     DEPTH       = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     fetch_ready_i,
    output logic [PC_W-1:0]          pc_o,
    output logic                     pc_valid_o,
    input  logic                     br_valid_i,
    input  logic                     br_take_i,
    input  logic                     br_spec_i,
    input  logic [PC_W-1:0]          br_pc_i,
    input  logic [PC_W-1:0]          br_target_i,
    input  logic                     resolve_valid_i,
    input  logic                     resolve_mispred_i,
    output logic                     stall_o,
    output logic                     redirect_o,
    output logic [PC_W-1:0]          redirect_pc_o,
    output logic [$clog2(DEPTH):0]   spec_count_o,
    output logic                     err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [PC_W-1:0] INC = PC_W'(INSTR_BYTES);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_W-1:0] r_q [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [PC_W-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_redirect;
    logic [PC_W-1:0] r_redirect_pc;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_accept;
    logic            w_flush;
    logic            w_push;
    logic [PC_W-1:0] w_alt;
    logic [PC_W-1:0] w_head;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_pop    = resolve_valid_i & ~w_empty;
    // A full queue can still take a speculative branch when the oldest
    // entry retires in the same cycle.
    assign w_accept = br_valid_i & (~br_spec_i | ~w_full | w_pop);
    assign w_flush  = w_pop & resolve_mispred_i;
    // A flush wipes younger checkpoints, including one arriving now.
    assign w_push   = w_accept & br_spec_i & ~w_flush;
    assign w_alt    = br_take_i ? (br_pc_i + INC) : br_target_i;
    assign w_head   = r_q[r_rd_ptr];

    assign stall_o  = br_valid_i & br_spec_i & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q[r_wr_ptr] <= w_alt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_pc          <= RESET_PC;
            r_pc_valid    <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_err         <= 1'b0;
        end else begin
            r_pc_valid <= 1'b1;
            r_redirect <= w_flush;

            if (w_flush) begin
                r_pc          <= w_head;
                r_redirect_pc <= w_head;
            end else if (w_accept && br_take_i) begin
                r_pc <= br_target_i;
            end else if (r_pc_valid && fetch_ready_i) begin
                r_pc <= r_pc + INC;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_flush) begin
                r_rd_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
                r_count  <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            if (resolve_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pc_o          = r_pc;
    assign pc_valid_o    = r_pc_valid;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign spec_count_o  = r_count;
    assign err_o         = r_err;

endmodule
